one_two_demux_32b_buf: RTL and testbench
========================================

Name: one_two_demux_32b_buf

Overview:
- Buffered 1-to-2 steering block for the pipelined datapath; the distributing counterpart of the 2:1 operand/result select muxes.
- Accepts one WIDTH-bit word per handshake and routes it to one of two destination channels, chosen by `select`.
- Each destination has its own small FIFO, so one stalled consumer never blocks words bound for the other channel once they have been accepted.
- Placed between a producing stage (e.g. EX/MEM result) and two consumers (e.g. register-file write path and HI/LO or store path).

Parameters:
- WIDTH, 32, data width of every channel.
- DEPTH, 2, entries per output FIFO. Must be a power of 2 and at least 2.
- CW, 2, width of the occupancy counters. Must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both FIFOs.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept the word addressed by `select`.
- in_data  input  WIDTH  upstream word.
- select  input  1  0 routes to channel 0, 1 routes to channel 1.
- out0_valid  output  1  channel 0 head word valid.
- out0_ready  input  1  channel 0 consumer takes the head word.
- out0_data  output  WIDTH  channel 0 head word.
- out1_valid  output  1  channel 1 head word valid.
- out1_ready  input  1  channel 1 consumer takes the head word.
- out1_data  output  WIDTH  channel 1 head word.
- out0_count  output  CW  channel 0 occupancy, 0..DEPTH.
- out1_count  output  CW  channel 1 occupancy, 0..DEPTH.

Behaviour:
- Reset: rst_n=0 asynchronously clears both FIFOs. Read and write pointers go to 0, counts to 0, out0_valid=out1_valid=0, out0_data=out1_data=0. in_ready reflects an empty FIFO, so it reads 1 during reset.
- Reset mid-operation: all buffered words are discarded. Nothing is emitted after rst_n rises until a new push.
- in_ready = (select ? out1_count : out0_count) < DEPTH.
  - It depends only on `select` and registered state, never on out*_ready. There is no combinational path from output to input.
- Push: occurs on a rising edge with in_valid & in_ready. in_data is written into the FIFO chosen by `select`. Only one channel is pushed per cycle.
- Pop on channel k: occurs on a rising edge with outk_valid & outk_ready. The read pointer advances.
- outk_valid = (outk_count != 0). outk_data is the FIFO head and is driven from storage, not from in_data.
- Latency: a word accepted at edge N is visible on outk_data/outk_valid after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Count update per channel:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, with the data ordering preserved.
  - neither: unchanged.
- Full channel (count==DEPTH), select pointing at it: in_ready=0 in that cycle even if that channel pops in the same cycle. The producer retries next cycle.
- Full channel, select pointing at the other channel: the other channel accepts normally.
- Empty channel with outk_ready=1: no pop, count stays 0, no underflow.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. FIFO order is strict per channel.
- Cross-channel ordering: not guaranteed. Words on channel 0 and channel 1 drain independently.
- flush=1 at an edge: both FIFOs are cleared (pointers and counts to 0). flush takes priority over a simultaneous push and pop; the pushed word is dropped.
  - in_ready is still computed normally while flush=1. A producer that needs the word must hold it off during flush.
- in_data and select are don't-care while in_valid=0. X on select with in_valid=0 must not corrupt state.

Test Plan:
1. Reset then single routing. Release rst_n. Push 0x0000_1111 with select=0, then 0x0000_2222 with select=1. Expect out0_valid=1 with 0x0000_1111 one cycle after the first push, and out1_valid=1 with 0x0000_2222 one cycle after the second. Each count=1.
2. Fill and backpressure. Hold out0_ready=0 and push 0xA, 0xB to channel 0. Expect out0_count=2 and in_ready=0 with select=0. With select=1, in_ready=1 and 0xC lands on channel 1.
3. Simultaneous push/pop and wrap. out0_ready=1 and a continuous stream 1,2,3,...,8 on channel 0. Expect out0_count steady at 1, output order 1..8 with no gaps after the first, and the pointers wrapping cleanly.
4. Full plus pop same cycle. Channel 0 holds 0xA, 0xB. Assert out0_ready=1 and in_valid=1, select=0, in_data=0xC. Expect in_ready=0 (0xC not taken) and 0xA popped. The next cycle in_ready=1, 0xC is accepted, and the output order is 0xA, 0xB, 0xC.
5. Flush priority. Both channels hold data. Assert flush together with a push of 0xDEAD_BEEF. Expect both counts=0, both valids=0 next cycle, and 0xDEAD_BEEF never appearing.
6. Async reset mid-stream. Drop rst_n between clock edges with count=2 on both channels. Expect the valids and counts to go to 0 immediately, without waiting for clk. After release, only freshly pushed words appear.

Source files
------------

// File: rtl/one_two_demux_32b_buf.sv
// Generic synchronous FIFO with registered head output and occupancy count.
// Latency: a pushed word is visible on head_dat/head_vld the cycle after the push edge.
// Backpressure: a push into a full FIFO is ignored; push_rdy depends only on registered count.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             head_vld,
  input  logic             head_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign push_rdy = (count_q < FULL_CNT);
  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Qualify handshakes so a full FIFO never overwrites and an empty one never underflows.
  always_comb begin
    push_en = push_vld && push_rdy;
    pop_en  = head_vld && head_rdy;
  end

  // Next-state for storage, pointers and count; flush wins over any push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears storage too so the head word reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// Buffered 1-to-2 steering: routes each accepted word to channel 0 or 1 by select.
// Latency: one cycle from accept edge to the word appearing at the channel head; no bypass.
// Backpressure: in_ready reflects only the selected channel's registered fullness, never out*_ready.
module one_two_demux_32b_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CW-1:0]    out0_count,
  output logic [CW-1:0]    out1_count
);

  logic push0_vld;
  logic push1_vld;
  logic push0_rdy;
  logic push1_rdy;

  // Steer the push to exactly one channel; in_valid gating keeps an unknown select harmless.
  always_comb begin
    push0_vld = in_valid && (select == 1'b0);
    push1_vld = in_valid && (select == 1'b1);
    in_ready  = select ? push1_rdy : push0_rdy;
  end

  fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_vld (push0_vld),
    .push_rdy (push0_rdy),
    .push_dat (in_data),
    .head_vld (out0_valid),
    .head_rdy (out0_ready),
    .head_dat (out0_data),
    .count    (out0_count)
  );

  fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_vld (push1_vld),
    .push_rdy (push1_rdy),
    .push_dat (in_data),
    .head_vld (out1_valid),
    .head_rdy (out1_ready),
    .head_dat (out1_data),
    .count    (out1_count)
  );

endmodule

// File: tb/tb_one_two_demux_32b_buf.sv
// Directed bench for one_two_demux_32b_buf with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Consumers are held off or enabled explicitly per step to exercise backpressure.
module tb_one_two_demux_32b_buf;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        select;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
  logic [1:0]  out0_count;
  logic [1:0]  out1_count;

  int errors = 0;
  int checks = 0;

  one_two_demux_32b_buf #(
    .WIDTH (32),
    .DEPTH (2),
    .CW    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .select     (select),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    select     = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #3;
    chk("rst_cnt0",   32'(out0_count), 32'd0);
    chk("rst_cnt1",   32'(out1_count), 32'd0);
    chk("rst_vld0",   32'(out0_valid), 32'd0);
    chk("rst_vld1",   32'(out1_valid), 32'd0);
    chk("rst_dat0",   out0_data, 32'h0);
    chk("rst_dat1",   out1_data, 32'h0);
    chk("rst_in_rdy", 32'(in_ready), 32'd1);
    // X on select with no valid must not disturb state
    select = 1'bx;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("x_sel_cnt0", 32'(out0_count), 32'd0);
    chk("x_sel_cnt1", 32'(out1_count), 32'd0);

    // 1. single routing
    in_valid = 1'b1; select = 1'b0; in_data = 32'h0000_1111;
    tick();
    chk("t1_vld0", 32'(out0_valid), 32'd1);
    chk("t1_dat0", out0_data, 32'h0000_1111);
    chk("t1_cnt0", 32'(out0_count), 32'd1);
    chk("t1_vld1_idle", 32'(out1_valid), 32'd0);
    select = 1'b1; in_data = 32'h0000_2222;
    tick();
    chk("t1_vld1", 32'(out1_valid), 32'd1);
    chk("t1_dat1", out1_data, 32'h0000_2222);
    chk("t1_cnt1", 32'(out1_count), 32'd1);
    chk("t1_cnt0_hold", 32'(out0_count), 32'd1);
    in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    chk("t1_drain0", 32'(out0_count), 32'd0);
    chk("t1_drain1", 32'(out1_count), 32'd0);
    out0_ready = 1'b0; out1_ready = 1'b0;

    // 2. fill channel 0 and backpressure
    in_valid = 1'b1; select = 1'b0; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    chk("t2_cnt0_full", 32'(out0_count), 32'd2);
    chk("t2_head0", out0_data, 32'hA);
    in_data = 32'hD;
    #1;
    chk("t2_rdy_full", 32'(in_ready), 32'd0);
    select = 1'b1; in_data = 32'hC;
    #1;
    chk("t2_rdy_other", 32'(in_ready), 32'd1);
    tick();
    chk("t2_cnt1", 32'(out1_count), 32'd1);
    chk("t2_dat1", out1_data, 32'hC);
    chk("t2_cnt0_kept", 32'(out0_count), 32'd2);

    // 4. full plus pop in the same cycle
    select = 1'b0; in_data = 32'hC; out0_ready = 1'b1;
    #1;
    chk("t4_rdy_full_pop", 32'(in_ready), 32'd0);
    chk("t4_head_a", out0_data, 32'hA);
    tick();
    chk("t4_cnt_after_pop", 32'(out0_count), 32'd1);
    chk("t4_head_b", out0_data, 32'hB);
    chk("t4_rdy_retry", 32'(in_ready), 32'd1);
    out1_ready = 1'b1;
    tick();
    chk("t4_cnt_pushpop", 32'(out0_count), 32'd1);
    chk("t4_head_c", out0_data, 32'hC);
    chk("t4_cnt1_drain", 32'(out1_count), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("t4_cnt0_empty", 32'(out0_count), 32'd0);
    chk("t4_vld0_empty", 32'(out0_valid), 32'd0);
    // empty channel with ready high: no underflow
    tick();
    chk("t4_no_underflow", 32'(out0_count), 32'd0);

    // 3. streaming push/pop with pointer wrap
    out0_ready = 1'b1; out1_ready = 1'b0; in_valid = 1'b1; select = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_data = 32'(i);
      tick();
      chk("t3_stream_dat", out0_data, 32'(i));
      chk("t3_stream_cnt", 32'(out0_count), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("t3_stream_end", 32'(out0_count), 32'd0);

    // 5. flush priority over a simultaneous push
    out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
    select = 1'b0; in_data = 32'h51; tick();
    in_data = 32'h52; tick();
    select = 1'b1; in_data = 32'h61; tick();
    chk("t5_pre_cnt0", 32'(out0_count), 32'd2);
    chk("t5_pre_cnt1", 32'(out1_count), 32'd1);
    flush = 1'b1; in_data = 32'hDEAD_BEEF; out0_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out0_ready = 1'b0;
    chk("t5_cnt0", 32'(out0_count), 32'd0);
    chk("t5_cnt1", 32'(out1_count), 32'd0);
    chk("t5_vld0", 32'(out0_valid), 32'd0);
    chk("t5_vld1", 32'(out1_valid), 32'd0);
    tick();
    chk("t5_vld1_later", 32'(out1_valid), 32'd0);
    in_valid = 1'b1; select = 1'b1; in_data = 32'h5;
    tick();
    in_valid = 1'b0;
    chk("t5_fresh_dat1", out1_data, 32'h5);
    chk("t5_fresh_cnt1", 32'(out1_count), 32'd1);
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
    chk("t5_fresh_drain", 32'(out1_count), 32'd0);

    // 6. async reset mid-stream
    in_valid = 1'b1; select = 1'b0; in_data = 32'h11; tick();
    in_data = 32'h12; tick();
    select = 1'b1; in_data = 32'h21; tick();
    in_data = 32'h22; tick();
    in_valid = 1'b0;
    chk("t6_pre_cnt0", 32'(out0_count), 32'd2);
    chk("t6_pre_cnt1", 32'(out1_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cnt0", 32'(out0_count), 32'd0);
    chk("t6_cnt1", 32'(out1_count), 32'd0);
    chk("t6_vld0", 32'(out0_valid), 32'd0);
    chk("t6_vld1", 32'(out1_valid), 32'd0);
    chk("t6_dat0", out0_data, 32'h0);
    #2;
    rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    chk("t6_post_vld0", 32'(out0_valid), 32'd0);
    chk("t6_post_vld1", 32'(out1_valid), 32'd0);
    out0_ready = 1'b0;
    in_valid = 1'b1; select = 1'b0; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    chk("t6_fresh_dat0", out0_data, 32'h77);
    chk("t6_fresh_cnt0", 32'(out0_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
